// File: rtl/spi_ctrl_pkg.sv
// Shared constants, state types and helpers for the SPI burst controller
// and its core register-access engine.
package spi_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned N_REQ  = 2;

  // SPI master core register map
  localparam logic [ADDR_W-1:0] ADDR_RX      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TX      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SS      = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_EOPV    = 3'd6;

  localparam int unsigned SSO_BIT = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SS,
    ST_SSO_ON,
    ST_TX_WAIT,
    ST_WR_DATA,
    ST_RX_WAIT,
    ST_RD_DATA,
    ST_RX_PUSH,
    ST_SSO_OFF,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ACC1,
    PH_ACC2,
    PH_GAP
  } acc_phase_e;

  // Control register value with only the SSO bit driven
  function automatic logic [DATA_W-1:0] ctrl_sso(input logic on);
    logic [DATA_W-1:0] v;
    v          = '0;
    v[SSO_BIT] = on;
    return v;
  endfunction

  function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Requester-side bundle of the SPI burst controller: burst request,
// tx/rx byte streams, grant and done.
interface spi_burst_ctrl_if #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned SS_W  = 16
) ();

  logic [1:0]         req_i;
  logic [2*SS_W-1:0]  ss_i;
  logic [2*LEN_W-1:0] len_i;
  logic [15:0]        tx_data_i;
  logic [1:0]         tx_valid_i;
  logic [1:0]         tx_ready_o;
  logic [7:0]         rx_data_o;
  logic [1:0]         rx_valid_o;
  logic [1:0]         rx_ready_i;
  logic [1:0]         gnt_o;
  logic [1:0]         done_o;

  modport master (
    output req_i, ss_i, len_i, tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, gnt_o, done_o
  );

  modport slave (
    input  req_i, ss_i, len_i, tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o, gnt_o, done_o
  );

endinterface

// File: rtl/spi_reg_access.sv
// One SPI core register access: two select cycles with stable addr/data and
// strobe low, then one idle cycle during which done_c is high.
module spi_reg_access
  import spi_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_c,
  output logic [DATA_W-1:0] rdata_o,
  output logic              spi_select_o,
  output logic [ADDR_W-1:0] spi_mem_addr_o,
  output logic              spi_write_n_o,
  output logic              spi_read_n_o,
  output logic [DATA_W-1:0] spi_data_from_cpu_o,
  input  logic [DATA_W-1:0] spi_data_to_cpu_i
);

  acc_phase_e phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q             <= PH_IDLE;
      rdata_o             <= '0;
      spi_select_o        <= 1'b0;
      spi_mem_addr_o      <= '0;
      spi_write_n_o       <= 1'b1;
      spi_read_n_o        <= 1'b1;
      spi_data_from_cpu_o <= '0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (start_i) begin
            spi_select_o        <= 1'b1;
            spi_mem_addr_o      <= addr_i;
            spi_data_from_cpu_o <= we_i ? wdata_i : '0;
            spi_write_n_o       <= ~we_i;
            spi_read_n_o        <= we_i;
            phase_q             <= PH_ACC1;
          end
        end
        PH_ACC1: phase_q <= PH_ACC2;
        PH_ACC2: begin
          // read data is taken at the close of the second select cycle
          if (!spi_read_n_o) rdata_o <= spi_data_to_cpu_i;
          spi_select_o  <= 1'b0;
          spi_write_n_o <= 1'b1;
          spi_read_n_o  <= 1'b1;
          phase_q       <= PH_GAP;
        end
        PH_GAP:  phase_q <= PH_IDLE;
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign done_c = (phase_q == PH_GAP);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Two-requester round-robin burst sequencer in front of an 8-bit SPI master
// core; keeps SS_n low through SSO for the whole burst, one byte in flight.
module spi_burst_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned SS_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  spi_burst_ctrl_if.slave   bus,
  output logic              busy_o,
  output logic              spi_select,
  output logic [ADDR_W-1:0] spi_mem_addr,
  output logic              spi_write_n,
  output logic              spi_read_n,
  output logic [DATA_W-1:0] spi_data_from_cpu,
  input  logic [DATA_W-1:0] spi_data_to_cpu,
  input  logic              spi_dataavailable,
  input  logic              spi_readyfordata
);

  state_e             state_q;
  logic               g_q;
  logic               last_q;
  logic [LEN_W-1:0]   rem_q;
  logic [N_REQ-1:0]   gnt_q, done_q, tx_ready_q, rx_valid_q;
  logic [BYTE_W-1:0]  rx_data_q;
  logic               busy_q;
  logic               acc_start_q, acc_we_q;
  logic [ADDR_W-1:0]  acc_addr_q;
  logic [DATA_W-1:0]  acc_wdata_q;
  logic               acc_done_c;
  logic [DATA_W-1:0]  acc_rdata;
  logic               unused_rdata_hi;

  // Tie goes to the requester that was not granted last
  logic               win_c;
  logic [SS_W-1:0]    win_ss_c;
  logic [LEN_W-1:0]   win_len_c;

  assign win_c     = (&bus.req_i) ? ~last_q : bus.req_i[1];
  assign win_ss_c  = bus.ss_i[win_c*SS_W +: SS_W];
  assign win_len_c = bus.len_i[win_c*LEN_W +: LEN_W];

  // RX_WAIT is always reached through RX_PUSH, TX_WAIT and a full WR_DATA
  // access, so RRDY is never re-sampled sooner than 2 cycles after a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      g_q         <= 1'b0;
      last_q      <= 1'b1;
      rem_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      tx_ready_q  <= '0;
      rx_valid_q  <= '0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
      acc_start_q <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else begin
      acc_start_q <= 1'b0;
      done_q      <= '0;
      case (state_q)
        ST_IDLE: begin
          // done_q gate: the finishing requester still holds req this cycle
          if ((|bus.req_i) && !(|done_q)) begin
            g_q    <= win_c;
            rem_q  <= win_len_c;
            gnt_q  <= req_onehot(win_c);
            busy_q <= 1'b1;
            if (win_len_c == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q     <= ST_WR_SS;
              acc_start_q <= 1'b1;
              acc_we_q    <= 1'b1;
              acc_addr_q  <= ADDR_SS;
              acc_wdata_q <= DATA_W'(win_ss_c);
            end
          end
        end
        ST_WR_SS: begin
          if (acc_done_c) begin
            state_q     <= ST_SSO_ON;
            acc_start_q <= 1'b1;
            acc_we_q    <= 1'b1;
            acc_addr_q  <= ADDR_CONTROL;
            acc_wdata_q <= ctrl_sso(1'b1);
          end
        end
        ST_SSO_ON: begin
          if (acc_done_c) state_q <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (tx_ready_q[g_q] && bus.tx_valid_i[g_q]) begin
            tx_ready_q  <= '0;
            if (rem_q != '0) rem_q <= rem_q - LEN_W'(1);
            state_q     <= ST_WR_DATA;
            acc_start_q <= 1'b1;
            acc_we_q    <= 1'b1;
            acc_addr_q  <= ADDR_TX;
            acc_wdata_q <= {8'h00, bus.tx_data_i[g_q*BYTE_W +: BYTE_W]};
          end else begin
            tx_ready_q <= req_onehot(g_q) & {N_REQ{spi_readyfordata}};
          end
        end
        ST_WR_DATA: begin
          if (acc_done_c) state_q <= ST_RX_WAIT;
        end
        ST_RX_WAIT: begin
          if (spi_dataavailable) begin
            state_q     <= ST_RD_DATA;
            acc_start_q <= 1'b1;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= ADDR_RX;
            acc_wdata_q <= '0;
          end
        end
        ST_RD_DATA: begin
          if (acc_done_c) begin
            rx_data_q  <= acc_rdata[BYTE_W-1:0];
            rx_valid_q <= req_onehot(g_q);
            state_q    <= ST_RX_PUSH;
          end
        end
        ST_RX_PUSH: begin
          if (rx_valid_q[g_q] && bus.rx_ready_i[g_q]) begin
            rx_valid_q <= '0;
            if (rem_q != '0) begin
              state_q <= ST_TX_WAIT;
            end else begin
              state_q     <= ST_SSO_OFF;
              acc_start_q <= 1'b1;
              acc_we_q    <= 1'b1;
              acc_addr_q  <= ADDR_CONTROL;
              acc_wdata_q <= ctrl_sso(1'b0);
            end
          end
        end
        ST_SSO_OFF: begin
          if (acc_done_c) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= req_onehot(g_q);
          gnt_q   <= '0;
          last_q  <= g_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spi_reg_access u_acc (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (acc_start_q),
    .we_i                (acc_we_q),
    .addr_i              (acc_addr_q),
    .wdata_i             (acc_wdata_q),
    .done_c              (acc_done_c),
    .rdata_o             (acc_rdata),
    .spi_select_o        (spi_select),
    .spi_mem_addr_o      (spi_mem_addr),
    .spi_write_n_o       (spi_write_n),
    .spi_read_n_o        (spi_read_n),
    .spi_data_from_cpu_o (spi_data_from_cpu),
    .spi_data_to_cpu_i   (spi_data_to_cpu)
  );

  assign unused_rdata_hi = ^acc_rdata[DATA_W-1:BYTE_W];

  assign bus.gnt_o      = gnt_q;
  assign bus.done_o     = done_q;
  assign bus.tx_ready_o = tx_ready_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.rx_data_o  = rx_data_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural SPI core (MISO looped
// to MOSI) and requester stimulus driven on the falling edge.
module tb_spi_burst_ctrl;
  import spi_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  spi_burst_ctrl_if #(.LEN_W(8), .SS_W(16)) bus ();

  logic        busy;
  logic        spi_select, spi_write_n, spi_read_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data_from_cpu, spi_data_to_cpu;
  logic        spi_dataavailable, spi_readyfordata;

  logic [1:0]  req_r, tx_valid_r, rx_ready_r;
  logic [15:0] tx_data_r, len_r;
  logic [31:0] ss_r;
  assign bus.req_i      = req_r;
  assign bus.tx_valid_i = tx_valid_r;
  assign bus.rx_ready_i = rx_ready_r;
  assign bus.tx_data_i  = tx_data_r;
  assign bus.len_i      = len_r;
  assign bus.ss_i       = ss_r;

  spi_burst_ctrl #(.LEN_W(8), .SS_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .busy_o            (busy),
    .spi_select        (spi_select),
    .spi_mem_addr      (spi_mem_addr),
    .spi_write_n       (spi_write_n),
    .spi_read_n        (spi_read_n),
    .spi_data_from_cpu (spi_data_from_cpu),
    .spi_data_to_cpu   (spi_data_to_cpu),
    .spi_dataavailable (spi_dataavailable),
    .spi_readyfordata  (spi_readyfordata)
  );

  // Behavioural SPI core: 16 cycles per byte, SCLK rising on even counts
  logic [15:0] m_ss, m_ctrl, m_tx, m_rx, m_ss_n;
  logic        m_rrdy, m_trdy, m_roe, m_shift, sel_d;
  int          m_cnt;
  int          sel_cnt = 0, wr1_cnt = 0, edge_lo_cnt = 0;
  logic [15:0] a3_log[$];

  assign m_ss_n            = m_ctrl[SSO_BIT] ? ~m_ss : 16'hFFFF;
  assign spi_data_to_cpu   = (spi_mem_addr == ADDR_RX) ? m_rx : 16'h0000;
  assign spi_dataavailable = m_rrdy;
  assign spi_readyfordata  = m_trdy;

  always @(posedge clk) begin
    sel_d <= spi_select;
    if (reset) begin
      m_ss <= '0; m_ctrl <= '0; m_tx <= '0; m_rx <= '0;
      m_rrdy <= 1'b0; m_trdy <= 1'b1; m_roe <= 1'b0; m_shift <= 1'b0; m_cnt <= 0;
    end else begin
      if (spi_select && !sel_d) begin
        sel_cnt <= sel_cnt + 1;
        if (!spi_write_n) begin
          case (spi_mem_addr)
            ADDR_SS:      m_ss <= spi_data_from_cpu;
            ADDR_CONTROL: begin m_ctrl <= spi_data_from_cpu; a3_log.push_back(spi_data_from_cpu); end
            ADDR_TX:      begin
              m_tx <= spi_data_from_cpu; m_trdy <= 1'b0; m_shift <= 1'b1; m_cnt <= 0;
              wr1_cnt <= wr1_cnt + 1;
            end
            default: ;
          endcase
        end
        if (!spi_read_n && spi_mem_addr == ADDR_RX) m_rrdy <= 1'b0;
      end
      if (m_shift) begin
        m_cnt <= m_cnt + 1;
        if ((m_cnt % 2) == 0 && !m_ss_n[0]) edge_lo_cnt <= edge_lo_cnt + 1;
        if (m_cnt == 15) begin
          m_shift <= 1'b0; m_rx <= m_tx; m_trdy <= 1'b1; m_rrdy <= 1'b1;
          if (m_rrdy) m_roe <= 1'b1;
        end
      end
    end
  end

  int done0_cnt = 0;
  always @(negedge clk) if (bus.done_o[0] === 1'b1) done0_cnt <= done0_cnt + 1;

  int n_chk = 0, n_err = 0;
  logic [7:0] txb[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Plays requester n through a granted burst of len bytes from txb[]
  task automatic serve(input int n, input int len, input int gap, input int hold);
    int t, w1;
    logic [7:0] d0;
    logic stable, sslow;
    logic [1:0] oh;
    oh = (n == 1) ? 2'b10 : 2'b01;
    t = 0;
    while (bus.gnt_o[n] !== 1'b1 && t < 100) begin tick(); t++; end
    chk("gnt", 32'(bus.gnt_o), 32'(oh));
    for (int k = 0; k < len; k++) begin
      if (k > 0 && gap > 0) begin
        w1 = wr1_cnt; sslow = 1'b1;
        repeat (gap) begin tick(); if (m_ss_n[n] !== 1'b0) sslow = 1'b0; end
        chk("gap_no_tx_wr", 32'(wr1_cnt), 32'(w1));
        chk("gap_ss_low", 32'(sslow), 32'd1);
      end
      tx_data_r[n*8 +: 8] = txb[k];
      tx_valid_r[n] = 1'b1;
      t = 0;
      while (bus.tx_ready_o[n] !== 1'b1 && t < 200) begin tick(); t++; end
      tick();
      tx_valid_r[n] = 1'b0;
      t = 0;
      while (bus.rx_valid_o[n] !== 1'b1 && t < 200) begin tick(); t++; end
      if (hold > 0 && k == 0) begin
        d0 = bus.rx_data_o; w1 = wr1_cnt; stable = 1'b1;
        repeat (hold) begin
          tick();
          if (bus.rx_valid_o[n] !== 1'b1 || bus.rx_data_o !== d0) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_no_tx_wr", 32'(wr1_cnt), 32'(w1));
      end
      chk($sformatf("rx%0d_req%0d", k, n), 32'(bus.rx_data_o), 32'(txb[k]));
      rx_ready_r[n] = 1'b1;
      tick();
      rx_ready_r[n] = 1'b0;
    end
    t = 0;
    while (bus.done_o[n] !== 1'b1 && t < 100) begin tick(); t++; end
    chk("done", 32'(bus.done_o), 32'(oh));
    req_r[n] = 1'b0;
    tick();
    chk("done_1cyc", 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int e0, a0, d0c, s0, w, t;
    req_r = '0; tx_valid_r = '0; rx_ready_r = '0; tx_data_r = '0;
    len_r = '0; ss_r = {16'h0002, 16'h0001};
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_txrdy", 32'(bus.tx_ready_o), 32'd0);
    chk("rst_rxvld", 32'(bus.rx_valid_o), 32'd0);
    chk("rst_rxdata", 32'(bus.rx_data_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(spi_select), 32'd0);
    chk("rst_wr_n", 32'(spi_write_n), 32'd1);
    chk("rst_rd_n", 32'(spi_read_n), 32'd1);
    chk("rst_addr", 32'(spi_mem_addr), 32'd0);
    chk("rst_wdata", 32'(spi_data_from_cpu), 32'd0);
    reset = 1'b0;
    tick();

    // Tie straight after reset: req0 then req1
    txb[0] = 8'h11; len_r = {8'd1, 8'd1}; req_r = 2'b11;
    serve(0, 1, 0, 0);
    serve(1, 1, 0, 0);

    // Single 3-byte burst on req0
    e0 = edge_lo_cnt; a0 = a3_log.size(); d0c = done0_cnt;
    txb[0] = 8'hA5; txb[1] = 8'h3C; txb[2] = 8'hFF;
    len_r = {8'd1, 8'd3}; req_r = 2'b01;
    serve(0, 3, 0, 0);
    repeat (2) tick();
    chk("sclk_ss_low_edges", 32'(edge_lo_cnt - e0), 32'd24);
    chk("sso_wr_count", 32'(a3_log.size() - a0), 32'd2);
    if (a3_log.size() >= a0 + 2) begin
      chk("sso_on", 32'(a3_log[a0]), 32'h0400);
      chk("sso_off", 32'(a3_log[a0+1]), 32'h0000);
    end
    chk("ss_reg", 32'(m_ss), 32'h0001);
    chk("done0_pulses", 32'(done0_cnt - d0c), 32'd1);
    chk("roe_t1", 32'(m_roe), 32'd0);

    // Tie after req0 was last granted: req1 then req0
    txb[0] = 8'h42; len_r = {8'd1, 8'd1}; req_r = 2'b11;
    serve(1, 1, 0, 0);
    serve(0, 1, 0, 0);

    // Empty burst on req1
    s0 = sel_cnt; len_r = {8'd0, 8'd1};
    req_r = 2'b10;
    tick();
    chk("len0_gnt", 32'(bus.gnt_o), 32'd2);
    chk("len0_done_early", 32'(bus.done_o), 32'd0);
    tick();
    chk("len0_done", 32'(bus.done_o), 32'd2);
    req_r = 2'b00;
    tick();
    chk("len0_done_1cyc", 32'(bus.done_o), 32'd0);
    chk("len0_no_select", 32'(sel_cnt - s0), 32'd0);

    // rx back-pressure for 50 cycles on byte 1
    txb[0] = 8'h5A; txb[1] = 8'hC3; len_r = {8'd1, 8'd2}; req_r = 2'b01;
    serve(0, 2, 0, 50);
    chk("roe_hold", 32'(m_roe), 32'd0);

    // Reset while waiting on RRDY
    tx_data_r[7:0] = 8'h77; tx_valid_r[0] = 1'b1; len_r = {8'd1, 8'd1};
    w = wr1_cnt; req_r = 2'b01; t = 0;
    while (wr1_cnt == w && t < 100) begin tick(); t++; end
    chk("rst_mid_txwr_seen", 32'(wr1_cnt - w), 32'd1);
    tx_valid_r[0] = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_wr_n", 32'(spi_write_n), 32'd1);
    chk("rst_mid_rd_n", 32'(spi_read_n), 32'd1);
    chk("rst_mid_rxvld", 32'(bus.rx_valid_o), 32'd0);
    reset = 1'b0; req_r = 2'b00;
    tick();
    txb[0] = 8'h99; req_r = 2'b01;
    serve(0, 1, 0, 0);

    // 100-cycle tx gap between bytes
    txb[0] = 8'hC0; txb[1] = 8'hDE; len_r = {8'd1, 8'd2}; req_r = 2'b01;
    serve(0, 2, 100, 0);
    chk("busy_end", 32'(busy), 32'd0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
